// File: rtl/exc_pkg.sv
// Shared definitions for the exception vector unit: cause codes, FSM states,
// default vector base and the request priority encoder.
package exc_pkg;

  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_DIV0   = 2'd2;

  localparam int unsigned VEC_BASE_DEFAULT = 32'd253;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Opcode beats overflow beats divide-by-zero; losers are simply dropped.
  function automatic logic [1:0] cause_of(input logic [2:0] req);
    logic [1:0] c;
    if (req[0]) begin
      c = CAUSE_OPCODE;
    end else if (req[1]) begin
      c = CAUSE_OVF;
    end else begin
      c = CAUSE_DIV0;
    end
    return c;
  endfunction

endpackage

// File: rtl/exception_vector_unit.sv
// Exception front-end: saves EPC and cause, fetches the handler byte from the
// vector table and strobes vec_valid so control can load PC from vector_pc.
module exception_vector_unit
  import exc_pkg::*;
#(
  parameter int unsigned VEC_BASE    = VEC_BASE_DEFAULT,
  parameter int unsigned MEM_LATENCY = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  exc_req,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] epc_out,
  output logic [1:0]  cause,
  output logic [31:0] vector_pc,
  output logic        vec_valid,
  output logic        busy
);

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [31:0] epc_r;
  logic [1:0]  cause_r;
  logic [31:0] vpc_r;
  logic        unused_data_s;

  // Only the low byte of a vector slot carries the handler address.
  assign unused_data_s = ^mem_data_in[31:8];

  // Sequence state, wait counter and the held EPC/cause/vector registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      epc_r   <= 32'd0;
      cause_r <= 2'd0;
      vpc_r   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (exc_req != 3'b000) begin
            epc_r   <= pc_in - 32'd4;
            cause_r <= cause_of(exc_req);
            cnt_r   <= 3'(MEM_LATENCY - 32'd1);
            state_r <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Data is only trusted on the last wait edge.
          if (cnt_r == 3'd0) begin
            vpc_r   <= {24'd0, mem_data_in[7:0]};
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r - 3'd1;
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the current state; address is forced to 0 outside reads.
  always_comb begin
    mem_rd    = 1'b0;
    mem_addr  = 32'd0;
    vec_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ISSUE, ST_WAIT: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = 32'(VEC_BASE) + {30'd0, cause_r};
      end
      ST_DONE: begin
        busy      = 1'b1;
        vec_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign epc_out   = epc_r;
  assign cause     = cause_r;
  assign vector_pc = vpc_r;

endmodule

// File: tb/tb_exception_vector_unit.sv
// Scoreboard bench for exception_vector_unit: one instance at the default
// latency and one at latency 4, sharing clock, reset and pc_in.
module tb_exception_vector_unit;

  typedef struct {
    int          inst;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [31:0] vpc;
    logic [31:0] addr;
    int          vcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [2:0]  req   [2];
  logic [31:0] md    [2];
  logic [31:0] maddr [2];
  logic        mrd   [2];
  logic [31:0] epc   [2];
  logic [1:0]  cause [2];
  logic [31:0] vpc   [2];
  logic        vv    [2];
  logic        busy  [2];

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   rd_cnt [2];

  always #5 clk = ~clk;

  exception_vector_unit #(.VEC_BASE(32'd253), .MEM_LATENCY(32'd1)) dut0 (
    .clk(clk), .reset(reset), .exc_req(req[0]), .pc_in(pc_in),
    .mem_data_in(md[0]), .mem_addr(maddr[0]), .mem_rd(mrd[0]),
    .epc_out(epc[0]), .cause(cause[0]), .vector_pc(vpc[0]),
    .vec_valid(vv[0]), .busy(busy[0])
  );

  exception_vector_unit #(.VEC_BASE(32'd253), .MEM_LATENCY(32'd4)) dut4 (
    .clk(clk), .reset(reset), .exc_req(req[1]), .pc_in(pc_in),
    .mem_data_in(md[1]), .mem_addr(maddr[1]), .mem_rd(mrd[1]),
    .epc_out(epc[1]), .cause(cause[1]), .vector_pc(vpc[1]),
    .vec_valid(vv[1]), .busy(busy[1])
  );

  // Vector table with upper data bits driven high so they must be ignored.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd253: return 8'h5A;
      32'd254: return 8'h9C;
      32'd255: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  assign md[0] = {24'hFFFFFF, mem_byte(maddr[0])};
  assign md[1] = {24'hFFFFFF, mem_byte(maddr[1])};

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input int k);
    chk("rst_addr",  maddr[k], 32'd0);
    chk("rst_rd",    {31'd0, mrd[k]}, 32'd0);
    chk("rst_epc",   epc[k], 32'd0);
    chk("rst_cause", {30'd0, cause[k]}, 32'd0);
    chk("rst_vpc",   vpc[k], 32'd0);
    chk("rst_valid", {31'd0, vv[k]}, 32'd0);
    chk("rst_busy",  {31'd0, busy[k]}, 32'd0);
  endtask

  task automatic request(input int k, input logic [2:0] bits, input logic [31:0] pc,
                         input logic [1:0] ec, input logic [31:0] eepc, input logic [31:0] evpc);
    exp_t e;
    @(negedge clk);
    req[k] = bits;
    pc_in  = pc;
    e.inst  = k;
    e.epc   = eepc;
    e.cause = ec;
    e.vpc   = evpc;
    e.addr  = 32'd253 + {30'd0, ec};
    e.vcyc  = cyc + 2 + lat(k);
    q.push_back(e);
    @(negedge clk);
    req[k] = 3'b000;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: read window, address, and scoreboard compare on each vec_valid.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        rd_cnt[k] = 0;
      end else begin
        if (mrd[k]) begin
          rd_cnt[k]++;
          if (q.size() > 0 && q[0].inst == k) chk("rd_addr", maddr[k], q[0].addr);
          else chk("rd_unexpected", {31'd0, mrd[k]}, 32'd0);
        end else begin
          chk("addr_idle", maddr[k], 32'd0);
        end
        if (vv[k]) begin
          if (q.size() == 0 || q[0].inst != k) begin
            chk("valid_unexpected", {31'd0, vv[k]}, 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("epc",   epc[k], e.epc);
            chk("cause", {30'd0, cause[k]}, {30'd0, e.cause});
            chk("vpc",   vpc[k], e.vpc);
            chk("vcyc",  cyc, e.vcyc);
            chk("rd_len", rd_cnt[k], lat(k) + 1);
            chk("busy_done", {31'd0, busy[k]}, 32'd1);
          end
          rd_cnt[k] = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    pc_in  = 32'd0;
    req[0] = 3'b000;
    req[1] = 3'b000;
    #2;
    chk_zero(0);
    chk_zero(1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Overflow at default latency.
    request(0, 3'b010, 32'h0000_0040, 2'd1, 32'h0000_003C, 32'h0000_009C);
    drain();

    // Simultaneous requests: opcode wins, the rest are dropped.
    request(0, 3'b111, 32'h0000_0100, 2'd0, 32'h0000_00FC, 32'h0000_005A);
    drain();
    chk("simul_cause", {30'd0, cause[0]}, 32'd0);
    chk("simul_idle", {31'd0, busy[0]}, 32'd0);

    // Div0 raised during WAIT of an opcode sequence is ignored.
    request(0, 3'b001, 32'h0000_0200, 2'd0, 32'h0000_01FC, 32'h0000_005A);
    @(negedge clk);
    req[0] = 3'b100;
    @(negedge clk);
    req[0] = 3'b000;
    drain();
    chk("busy_cause", {30'd0, cause[0]}, 32'd0);

    // Long latency div0.
    request(1, 3'b100, 32'h0000_1000, 2'd2, 32'h0000_0FFC, 32'h0000_00FF);
    drain();

    // Asynchronous reset during WAIT, then a fresh request.
    request(1, 3'b001, 32'h0000_3000, 2'd0, 32'h0000_2FFC, 32'h0000_005A);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_zero(1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_epc", epc[1], 32'd0);
    request(1, 3'b010, 32'h0000_0044, 2'd1, 32'h0000_0040, 32'h0000_009C);
    drain();

    // EPC wraps modulo 2^32.
    request(0, 3'b001, 32'h0000_0000, 2'd0, 32'hFFFF_FFFC, 32'h0000_005A);
    drain();
    chk("wrap_hold", epc[0], 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/exception_vector_unit.md
# exception_vector_unit

Sequential exception front-end for the multicycle CPU, sitting directly upstream of the PC-source multiplexer. On an exception request it latches the faulting PC into EPC, reads the handler-address byte from memory, and presents the zero-extended handler address to the PC-source mux. It then pulses a one-cycle load strobe so the control unit selects that mux input and writes PC. It owns EPC and the cause code; the control unit only raises requests and reacts to `vec_valid`.

## Interface
Parameters:
- `VEC_BASE`, default 253: byte address of the first vector slot. Slots are `VEC_BASE+0`, `+1` and `+2`.
- `MEM_LATENCY`, default 1: cycles from the first `mem_rd` cycle to valid `mem_data_in`. Legal range 1–7.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `exc_req`  in  3  request bits: [0] invalid opcode, [1] overflow, [2] divide-by-zero.
- `pc_in`  in  32  current PC value, already incremented by 4 when the request arrives.
- `mem_data_in`  in  32  memory read data; only bits [7:0] are used.
- `mem_addr`  out  32  vector address to memory.
- `mem_rd`  out  1  memory read enable.
- `epc_out`  out  32  saved exception PC.
- `cause`  out  2  latched cause code.
- `vector_pc`  out  32  handler address; feeds a PC-source mux data input.
- `vec_valid`  out  1  one-cycle strobe: select `vector_pc` and write PC this cycle.
- `busy`  out  1  high whenever the unit is not in IDLE.

## Operation
- **Cause encoding** (package constants): 2'd0 opcode, 2'd1 overflow, 2'd2 div0. 2'd3 is reserved and never produced.
- **Priority** when several `exc_req` bits are set in the same cycle: opcode > overflow > div0. Only the winner is serviced; the others are dropped.
- **States:** IDLE, ISSUE, WAIT, DONE.
  - IDLE: when `exc_req != 0` at a rising edge, latch `epc_out = pc_in - 32'd4`, latch `cause`, load the wait counter with `MEM_LATENCY-1`, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mem_rd=1`, `mem_addr = VEC_BASE + cause`. If `MEM_LATENCY==1`, go to WAIT with the counter at 0; otherwise go to WAIT.
  - WAIT: `mem_rd=1` and `mem_addr` held. The counter decrements each cycle. At the edge where the counter is 0, capture `vector_pc = {24'b0, mem_data_in[7:0]}` and go to DONE.
  - DONE: `vec_valid=1` for exactly this cycle, `mem_rd=0`, then return to IDLE.
- **Busy behaviour:** `exc_req` is ignored while `busy=1`. A request still asserted on the cycle after DONE starts a new sequence.
- **Output holding:**
  - `epc_out`, `cause` and `vector_pc` hold their values until overwritten by the next exception.
  - `mem_addr` is 0 whenever `mem_rd=0`.
- **Arithmetic:** the EPC subtraction is modulo 2^32, so `pc_in=0` yields 32'hFFFF_FFFC. Vector address arithmetic is 32-bit unsigned.

## Timing
- **Reset values:** all outputs 0 and state IDLE. This holds immediately on `reset` assertion, independent of `clk`.
- **Reset mid-sequence:** the sequence aborts, no `vec_valid` is produced, and EPC is cleared.
- **Latency:** a request sampled at edge N gives ISSUE in cycle N+1 and WAIT in cycles N+2 through N+1+MEM_LATENCY. `vec_valid` is high in cycle N+2+MEM_LATENCY. With the default latency, that is 3 cycles after the sampling edge.
- **Memory read window:** `mem_rd` stays high continuously from ISSUE through the end of WAIT, which is `MEM_LATENCY+1` cycles.
- **Data sampling:** `mem_data_in` is sampled only at the final WAIT edge; values at other times are don't-care.
- **Output validity:** `vector_pc` is valid from the start of DONE and remains stable afterwards. Control may write PC on the DONE edge.

## Structure
- **Shared package `exc_pkg`:** cause codes, the state enum (2-bit), and the default `VEC_BASE`.
- **No sub-module required.** The wait counter is a 3-bit register inside the block.
- **Single always-block state register** plus a combinational output decode. `vec_valid` is decoded from state DONE, not registered separately.

## Test plan
- **Overflow, default latency:** `exc_req=3'b010`, `pc_in=32'h0000_0040`, memory byte at 254 = 8'h9C. Expect `mem_addr=254` with `mem_rd` high for 2 cycles. Expect `epc_out=32'h3C`, `cause=1`, and `vector_pc=32'h9C` with `vec_valid` pulsing exactly once, 3 cycles after the request edge.
- **Simultaneous requests:** `exc_req=3'b111`. Expect `cause=0` and `mem_addr=253`; the other requests are not serviced afterwards once `exc_req` is cleared.
- **Request while busy:** div0 during WAIT of an opcode sequence. Expect it ignored: single `vec_valid`, `cause` stays 0.
- **Long latency:** `MEM_LATENCY=4`, div0, byte at 255 = 8'hFF. Expect `mem_rd` high for 5 cycles, `vec_valid` at cycle N+6, and `vector_pc=32'hFF` (upper `mem_data_in` bits set to 1 must be ignored).
- **Reset mid-operation:** assert `reset` asynchronously during WAIT. Expect all outputs 0 immediately, no `vec_valid`, and a fresh request after release to complete normally.
- **EPC wrap:** `pc_in=0` with an opcode request. Expect `epc_out=32'hFFFF_FFFC`.
